// File: rtl/ts_packet_sync.sv
// MPEG-2 TS receive framer: hunts for the sync byte, confirms packet spacing,
// then forwards aligned packets with sop/eop markers and extracts PID/TEI.
module ts_packet_sync #(
  parameter int unsigned           DATA_WIDTH    = 8,
  parameter int unsigned           PKT_LEN       = 188,
  parameter logic [DATA_WIDTH-1:0] SYNC_BYTE     = DATA_WIDTH'(8'h47),
  parameter int unsigned           LOCK_THRESH   = 3,
  parameter int unsigned           UNLOCK_THRESH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid,
  input  logic [DATA_WIDTH-1:0] byte_data,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  sop,
  output logic                  eop,
  output logic                  locked,
  output logic [12:0]           pid,
  output logic                  tei,
  output logic                  pid_valid,
  output logic                  sync_err,
  output logic [15:0]           pkt_count
);

  localparam int unsigned      IDX_W       = $clog2(PKT_LEN);
  localparam int unsigned      SCNT_W      = $clog2(LOCK_THRESH + 1);
  localparam int unsigned      MCNT_W      = $clog2(UNLOCK_THRESH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(PKT_LEN - 1);
  localparam logic             DIRECT_LOCK = (LOCK_THRESH == 32'd1);

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

  state_t              state;
  logic [IDX_W-1:0]    byte_idx;
  logic [SCNT_W-1:0]   sync_cnt;
  logic [MCNT_W-1:0]   miss_cnt;

  logic                is_sync;
  logic                idx_zero;
  logic [IDX_W-1:0]    idx_next;
  logic [SCNT_W-1:0]   sync_inc;
  logic [MCNT_W-1:0]   miss_inc;
  logic                lock_now;
  logic                unlock_now;
  logic                fwd;

  // Per-byte decisions: lock/unlock events and whether this byte is forwarded
  always_comb begin
    is_sync    = (byte_data == SYNC_BYTE);
    idx_zero   = (byte_idx == '0);
    idx_next   = (byte_idx == LAST_IDX) ? '0 : byte_idx + IDX_W'(1);
    sync_inc   = sync_cnt + SCNT_W'(1);
    miss_inc   = miss_cnt + MCNT_W'(1);
    lock_now   = 1'b0;
    unlock_now = 1'b0;
    if (valid) begin
      case (state)
        HUNT:    lock_now   = is_sync && DIRECT_LOCK;
        VERIFY:  lock_now   = idx_zero && is_sync && (sync_inc >= SCNT_W'(LOCK_THRESH));
        LOCKED:  unlock_now = idx_zero && !is_sync && (miss_inc >= MCNT_W'(UNLOCK_THRESH));
        default: ;
      endcase
    end
    fwd = valid && (((state == LOCKED) && !unlock_now) || lock_now);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      byte_idx  <= '0;
      sync_cnt  <= '0;
      miss_cnt  <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      locked    <= 1'b0;
      pid       <= '0;
      tei       <= 1'b0;
      pid_valid <= 1'b0;
      sync_err  <= 1'b0;
      pkt_count <= '0;
    end else begin
      out_valid <= 1'b0;
      sop       <= 1'b0;
      eop       <= 1'b0;
      pid_valid <= 1'b0;
      sync_err  <= 1'b0;

      // Output path; byte_idx is 0 on the locking byte in every state
      if (fwd) begin
        out_valid <= 1'b1;
        out_data  <= byte_data;
        sop       <= idx_zero;
        eop       <= (byte_idx == LAST_IDX);
        if (idx_zero) pkt_count <= pkt_count + 16'd1;
        if (byte_idx == IDX_W'(1)) begin
          tei       <= byte_data[7];
          pid[12:8] <= byte_data[4:0];
        end
        if (byte_idx == IDX_W'(2)) begin
          pid[7:0]  <= byte_data[7:0];
          pid_valid <= 1'b1;
        end
      end

      if (valid) begin
        case (state)
          HUNT: begin
            if (is_sync) begin
              byte_idx <= IDX_W'(1);
              sync_cnt <= SCNT_W'(1);
              miss_cnt <= '0;
              state    <= DIRECT_LOCK ? LOCKED : VERIFY;
              locked   <= DIRECT_LOCK;
            end
          end
          VERIFY: begin
            byte_idx <= idx_next;
            if (idx_zero) begin
              if (is_sync) begin
                sync_cnt <= sync_inc;
                if (lock_now) begin
                  state    <= LOCKED;
                  locked   <= 1'b1;
                  miss_cnt <= '0;
                end
              end else begin
                state    <= HUNT;
                sync_cnt <= '0;
                byte_idx <= '0;
              end
            end
          end
          LOCKED: begin
            byte_idx <= idx_next;
            if (idx_zero) begin
              if (is_sync) begin
                miss_cnt <= '0;
              end else begin
                sync_err <= 1'b1;
                miss_cnt <= miss_inc;
              end
            end
            // Too many missing syncs: drop lock and discard this byte
            if (unlock_now) begin
              state    <= HUNT;
              locked   <= 1'b0;
              byte_idx <= '0;
              sync_cnt <= '0;
              miss_cnt <= '0;
            end
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ts_packet_sync.sv
// Scoreboard bench for ts_packet_sync: a byte-stream reference model pushes
// expected output events; a negedge monitor pops and compares them.
module tb_ts_packet_sync;

  localparam int unsigned PKT_LEN = 188;
  localparam int unsigned LT      = 3;
  localparam int unsigned UT      = 3;
  localparam logic [7:0]  SYNC    = 8'h47;

  typedef struct packed {
    logic        ov;
    logic [7:0]  data;
    logic        sop;
    logic        eop;
    logic        pv;
    logic [12:0] pid;
    logic        tei;
    logic        serr;
    logic [15:0] cnt;
    logic        lk;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid;
  logic [7:0]  byte_data;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        sop, eop, locked, tei, pid_valid, sync_err;
  logic [12:0] pid;
  logic [15:0] pkt_count;

  int checks   = 0;
  int failures = 0;
  int ov_cnt   = 0;
  int serr_cnt = 0;

  obs_t       sb_q[$];
  logic [7:0] out_log[$];

  // Reference model state: position derives from absolute accepted-byte count
  int          m_mode;   // 0 hunt, 1 verify, 2 locked
  longint      m_n, m_anchor;
  int          m_syncs, m_miss;
  logic [12:0] m_pid;
  logic        m_tei;
  logic [15:0] m_cnt;

  ts_packet_sync dut (
    .clk(clk), .rst(rst), .valid(valid), .byte_data(byte_data),
    .out_valid(out_valid), .out_data(out_data), .sop(sop), .eop(eop),
    .locked(locked), .pid(pid), .tei(tei), .pid_valid(pid_valid),
    .sync_err(sync_err), .pkt_count(pkt_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_n = 0; m_anchor = 0; m_syncs = 0; m_miss = 0;
    m_pid = '0; m_tei = 1'b0; m_cnt = '0;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit   emit = 0;
    bit   serr = 0;
    int   pos;
    obs_t e;
    pos = int'((m_n - m_anchor) % longint'(PKT_LEN));
    case (m_mode)
      0: if (b == SYNC) begin
        m_anchor = m_n; m_syncs = 1;
        if (LT == 1) begin m_mode = 2; m_miss = 0; emit = 1; end
        else m_mode = 1;
      end
      1: if (pos == 0) begin
        if (b == SYNC) begin
          m_syncs++;
          if (m_syncs >= LT) begin m_mode = 2; m_miss = 0; emit = 1; end
        end else m_mode = 0;
      end
      default: begin
        emit = 1;
        if (pos == 0 && b != SYNC) begin
          serr = 1; m_miss++;
          if (m_miss >= UT) begin m_mode = 0; emit = 0; end
        end else if (pos == 0) m_miss = 0;
      end
    endcase
    pos = int'((m_n - m_anchor) % longint'(PKT_LEN));
    e = '0;
    if (emit) begin
      if (pos == 0) m_cnt = m_cnt + 16'd1;
      if (pos == 1) begin m_tei = b[7]; m_pid[12:8] = b[4:0]; end
      if (pos == 2) m_pid[7:0] = b;
      e.ov = 1'b1; e.data = b; e.sop = (pos == 0); e.eop = (pos == PKT_LEN - 1);
      e.pv = (pos == 2);
    end
    if (emit || serr) begin
      e.pid = m_pid; e.tei = m_tei; e.serr = serr; e.cnt = m_cnt; e.lk = (m_mode == 2);
      sb_q.push_back(e);
    end
    m_n++;
  endtask

  // Monitor: every cycle with an output event is matched against the queue
  always @(negedge clk) begin
    obs_t a, e;
    if (out_valid || sync_err || sop || eop || pid_valid) begin
      a.ov = out_valid; a.data = out_valid ? out_data : 8'h00; a.sop = sop; a.eop = eop;
      a.pv = pid_valid; a.pid = pid; a.tei = tei; a.serr = sync_err; a.cnt = pkt_count;
      a.lk = locked;
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL sb_unexpected t=%0t got=%h", $time, a);
      end else begin
        e = sb_q.pop_front();
        if (a !== e) begin
          failures++;
          $display("FAIL sb_event t=%0t got=%h exp=%h", $time, a, e);
        end
      end
      if (out_valid) begin ov_cnt++; out_log.push_back(out_data); end
      if (sync_err) serr_cnt++;
    end
  end

  function automatic logic [7:0] rnd_byte();
    logic [7:0] b;
    b = 8'($urandom);
    if (b == SYNC) b = 8'h46;
    return b;
  endfunction

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send(input logic [7:0] b, input int gap_pct);
    while (32'($urandom_range(99)) < gap_pct) begin
      valid = 1'b0;
      @(posedge clk); #1;
    end
    valid = 1'b1; byte_data = b;
    model_byte(b);
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic send_pkt(input logic [7:0] h0, input int gap_pct);
    send(h0, gap_pct);
    for (int i = 1; i < PKT_LEN; i++) send(rnd_byte(), gap_pct);
  endtask

  task automatic do_reset();
    rst = 1'b1; valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic chk_zero(input string name);
    chk(name, {out_valid, out_data, sop, eop, locked, pid, tei, pid_valid, sync_err, pkt_count}, 64'd0);
  endtask

  logic [7:0] stream_a[$];
  logic [7:0] log_a[$];
  int         snap, snap_e;

  initial begin
    rst = 1'b1; valid = 1'b0; byte_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_zero("reset_values");

    // Five clean packets; the third carries PID 0x1FFF, TEI 0
    for (int p = 0; p < 5; p++) begin
      stream_a.push_back(SYNC);
      stream_a.push_back(p == 2 ? 8'h1F : rnd_byte());
      stream_a.push_back(p == 2 ? 8'hFF : rnd_byte());
      for (int i = 3; i < PKT_LEN; i++) stream_a.push_back(rnd_byte());
    end

    for (int run = 0; run < 2; run++) begin
      if (run == 1) do_reset();
      out_log.delete();
      for (int i = 0; i < stream_a.size(); i++) begin
        send(stream_a[i], run == 0 ? 0 : 30);
        if (i == 375) chk("no_out_before_lock", 64'(ov_cnt), 64'(0 + (run == 0 ? 0 : 0) + (run == 1 ? log_a.size() : 0)));
        if (i == 376) chk("first_sop", {out_valid, sop, locked, out_data}, {3'b111, SYNC});
        if (i == 378) chk("pid_lock_hdr", {out_valid, pid_valid, pid, tei}, {2'b11, 13'h1FFF, 1'b0});
      end
      idle(2);
      chk("pkt_count_5pkts", 64'(pkt_count), 64'd3);
      chk("out_len", 64'(out_log.size()), 64'(3 * PKT_LEN));
      if (run == 0) begin
        log_a = out_log;
      end else begin
        checks++;
        if (out_log != log_a) begin
          failures++;
          $display("FAIL gap_equiv got_len=%0d exp_len=%0d", out_log.size(), log_a.size());
        end
      end
    end

    // One corrupted sync while locked: flywheel keeps the lock
    snap_e = serr_cnt;
    send_pkt(8'h00, 10);
    send_pkt(SYNC, 10);
    idle(2);
    chk("single_serr", 64'(serr_cnt - snap_e), 64'd1);
    chk("flywheel_locked", 64'(locked), 64'd1);
    chk("flywheel_count", 64'(pkt_count), 64'd5);

    // Three consecutive corrupted syncs drop lock; three fresh syncs re-lock
    snap_e = serr_cnt;
    for (int k = 0; k < 3; k++) send_pkt(8'h00, 0);
    idle(2);
    chk("triple_serr", 64'(serr_cnt - snap_e), 64'd3);
    chk("unlocked", 64'(locked), 64'd0);
    snap = ov_cnt;
    send_pkt(SYNC, 0);
    send_pkt(SYNC, 0);
    idle(2);
    chk("no_out_relock", 64'(ov_cnt - snap), 64'd0);
    send_pkt(SYNC, 0);
    idle(2);
    chk("relock_out", 64'(ov_cnt - snap), 64'(PKT_LEN));
    chk("relocked", 64'(locked), 64'd1);

    // Payload sync candidate with nothing 188 bytes later
    do_reset();
    snap = ov_cnt;
    send(SYNC, 0);
    for (int i = 0; i < 400; i++) send(rnd_byte(), 0);
    idle(2);
    chk("false_sync_no_out", 64'(ov_cnt - snap), 64'd0);
    chk("false_sync_unlocked", 64'(locked), 64'd0);

    // Reset mid-packet while locked
    do_reset();
    for (int k = 0; k < 3; k++) send_pkt(SYNC, 0);
    send(SYNC, 0);
    for (int i = 1; i < 90; i++) send(rnd_byte(), 0);
    chk("midpkt_locked", 64'(locked), 64'd1);
    do_reset();
    chk_zero("midpkt_reset");

    // Random stream with occasional corrupted syncs and gaps
    do_reset();
    for (int p = 0; p < 14; p++)
      send_pkt((32'($urandom_range(99)) < 15) ? 8'h00 : SYNC, 20);
    idle(3);
    chk("sb_drained", 64'(sb_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
